// File: rtl/pb_gpo_pkg.sv
// +-----------------------------------------------------------------------+
// | pb_gpo_pkg                                                            |
// | Register offsets and pulse FSM state encodings for pb_gpo.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package pb_gpo_pkg;

    localparam logic [2:0] GPO_DATA   = 3'd0;
    localparam logic [2:0] GPO_ENABLE = 3'd1;
    localparam logic [2:0] GPO_SET    = 3'd2;
    localparam logic [2:0] GPO_CLR    = 3'd3;
    localparam logic [2:0] GPO_TOGGLE = 3'd4;
    localparam logic [2:0] GPO_PSTART = 3'd5;
    localparam logic [2:0] GPO_PLEN   = 3'd6;
    localparam logic [2:0] GPO_STATUS = 3'd7;

    typedef enum logic [0:0] {
        GPO_IDLE  = 1'b0,
        GPO_PULSE = 1'b1
    } gpo_state_t;

endpackage

`default_nettype wire

// File: rtl/pb_gpo_pulse.sv
// +-----------------------------------------------------------------------+
// | pb_gpo_pulse                                                          |
// | Timed one-shot inversion mask with retrigger, sticky done and irq.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module pb_gpo_pulse
    import pb_gpo_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic [7:0] len,
    input  logic       clr_done,
    output logic [7:0] pmask,
    output logic       done,
    output logic       busy,
    output logic       irq
);

    gpo_state_t r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_pmask, w_pmask_nxt;
    logic       r_done, w_done_nxt;
    logic       r_irq, w_irq_nxt;
    logic       w_go;

    assign w_go = start && (mask != 8'd0) && (len != 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pmask_nxt = r_pmask;
        w_irq_nxt   = 1'b0;
        w_done_nxt  = clr_done ? 1'b0 : r_done;
        case (r_state)
            GPO_IDLE: begin
                if (w_go) begin
                    w_state_nxt = GPO_PULSE;
                    w_pmask_nxt = mask;
                    w_cnt_nxt   = len;
                end
            end
            GPO_PULSE: begin
                // A retrigger takes priority over expiry on the same cycle
                if (w_go) begin
                    w_pmask_nxt = r_pmask | mask;
                    w_cnt_nxt   = len;
                end else if (r_cnt == 8'd1) begin
                    w_state_nxt = GPO_IDLE;
                    w_pmask_nxt = 8'd0;
                    w_cnt_nxt   = 8'd0;
                    w_done_nxt  = 1'b1;
                    w_irq_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = GPO_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= GPO_IDLE;
            r_cnt   <= 8'd0;
            r_pmask <= 8'd0;
            r_done  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pmask <= w_pmask_nxt;
            r_done  <= w_done_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    assign pmask = r_pmask;
    assign done  = r_done;
    assign busy  = (r_state == GPO_PULSE);
    assign irq   = r_irq;

endmodule

`default_nettype wire

// File: rtl/pb_gpo.sv
// +-----------------------------------------------------------------------+
// | pb_gpo                                                                |
// | PicoBlaze general purpose output: 8 pins, set/clr/toggle, one-shot.   |
// | Pulse feature built only when PB_GPO_PULSE_EN is defined.             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module pb_gpo
    import pb_gpo_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR     = 8'h10,
    parameter logic [7:0] PULSE_LEN_RST = 8'd1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic [7:0] gpo,
    output logic       busy_o,
    output logic       int_o
);

    logic       w_hit;
    logic       w_wr;
    logic [2:0] w_off;
    logic [7:0] r_data, w_data_nxt;
    logic [7:0] r_enable;
    logic [7:0] r_gpo;
    logic [7:0] r_in_port, w_rd;
    logic [7:0] w_pmask;
    logic [7:0] w_plen;
    logic       w_done;
    logic       w_busy;
    logic       w_irq;

    assign w_hit = (port_id[7:3] == BASE_ADDR[7:3]);
    assign w_wr  = write_strobe && w_hit;
    assign w_off = port_id[2:0];

`ifdef PB_GPO_PULSE_EN
    logic [7:0] r_pulse_len;
    logic       w_start;
    logic       w_clr;

    assign w_start = w_wr && (w_off == GPO_PSTART);
    assign w_clr   = read_strobe && (port_id == {BASE_ADDR[7:3], GPO_STATUS});

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pulse_len <= PULSE_LEN_RST;
        end else if (w_wr && (w_off == GPO_PLEN)) begin
            r_pulse_len <= out_port;
        end
    end

    pb_gpo_pulse u_pulse (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start    (w_start),
        .mask     (out_port),
        .len      (r_pulse_len),
        .clr_done (w_clr),
        .pmask    (w_pmask),
        .done     (w_done),
        .busy     (w_busy),
        .irq      (w_irq)
    );

    assign w_plen = r_pulse_len;
`else
    logic w_unused_rd;

    assign w_unused_rd = read_strobe;
    assign w_pmask     = 8'd0;
    assign w_plen      = 8'd0;
    assign w_done      = 1'b0;
    assign w_busy      = 1'b0;
    assign w_irq       = 1'b0;
`endif

    always_comb begin
        w_data_nxt = r_data;
        if (w_wr) begin
            case (w_off)
                GPO_DATA:   w_data_nxt = out_port;
                GPO_SET:    w_data_nxt = r_data | out_port;
                GPO_CLR:    w_data_nxt = r_data & ~out_port;
                GPO_TOGGLE: w_data_nxt = r_data ^ out_port;
                default:    w_data_nxt = r_data;
            endcase
        end
    end

    // Pulse-only registers read as zero when the feature is not built
    always_comb begin
        w_rd = 8'd0;
        if (w_hit) begin
            case (w_off)
                GPO_DATA:   w_rd = r_data;
                GPO_ENABLE: w_rd = r_enable;
                GPO_PSTART: w_rd = w_pmask;
                GPO_PLEN:   w_rd = w_plen;
                GPO_STATUS: w_rd = {6'd0, w_done, w_busy};
                default:    w_rd = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_data    <= 8'd0;
            r_enable  <= 8'd0;
            r_gpo     <= 8'd0;
            r_in_port <= 8'd0;
        end else begin
            r_data    <= w_data_nxt;
            if (w_wr && (w_off == GPO_ENABLE)) begin
                r_enable <= out_port;
            end
            r_gpo     <= (r_data ^ w_pmask) & r_enable;
            r_in_port <= w_rd;
        end
    end

    assign gpo     = r_gpo;
    assign in_port = r_in_port;
    assign busy_o  = w_busy;
    assign int_o   = w_irq;

endmodule

`default_nettype wire

// File: tb/tb_pb_gpo.sv
// +-----------------------------------------------------------------------+
// | tb_pb_gpo                                                             |
// | Directed and randomized bench for pb_gpo with a behavioural model.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_pb_gpo;

    localparam logic [7:0] BASE  = 8'h10;
    localparam logic [7:0] PLRST = 8'd1;
`ifdef PB_GPO_PULSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic [7:0] gpo;
    logic       busy_o;
    logic       int_o;

    always #5 clk_i = ~clk_i;

    pb_gpo #(
        .BASE_ADDR     (BASE),
        .PULSE_LEN_RST (PLRST)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .gpo          (gpo),
        .busy_o       (busy_o),
        .int_o        (int_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pulse tracked as a number of remaining active cycles
    logic [7:0] m_data, m_en, m_len, m_pmask;
    logic       m_done;
    int         m_remain;
    logic [7:0] m_gpo, m_in;
    logic       m_busy, m_int;

    task automatic model_step();
        logic [7:0] rd;
        logic [7:0] new_len;
        logic       restarted;
        logic       expired;
        if (!rst_i) begin
            m_data = 0; m_en = 0; m_len = PLRST; m_pmask = 0; m_done = 0;
            m_remain = 0; m_gpo = 0; m_in = 0; m_busy = 0; m_int = 0;
            return;
        end
        m_gpo = (m_data ^ m_pmask) & m_en;
        rd = 8'h00;
        if (port_id[7:3] == BASE[7:3]) begin
            case (port_id[2:0])
                3'd0: rd = m_data;
                3'd1: rd = m_en;
                3'd5: rd = PEN ? m_pmask : 8'h00;
                3'd6: rd = PEN ? m_len : 8'h00;
                3'd7: rd = PEN ? {6'd0, m_done, m_remain > 0} : 8'h00;
                default: rd = 8'h00;
            endcase
        end
        m_in = rd;
        new_len   = m_len;
        restarted = 1'b0;
        expired   = 1'b0;
        if (write_strobe && port_id[7:3] == BASE[7:3]) begin
            case (port_id[2:0])
                3'd0: m_data = out_port;
                3'd1: m_en   = out_port;
                3'd2: m_data = m_data | out_port;
                3'd3: m_data = m_data & ~out_port;
                3'd4: m_data = m_data ^ out_port;
                3'd5: if (PEN && out_port != 0 && m_len != 0) begin
                    m_pmask   = m_pmask | out_port;
                    m_remain  = int'(m_len);
                    restarted = 1'b1;
                end
                3'd6: if (PEN) new_len = out_port;
                default: ;
            endcase
        end
        if (!restarted && m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
                m_pmask = 0;
                expired = 1'b1;
            end
        end
        if (read_strobe && port_id == (BASE | 8'd7)) m_done = 1'b0;
        if (expired) m_done = 1'b1;
        m_int  = expired;
        m_len  = new_len;
        m_busy = (m_remain > 0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        chk("gpo", gpo, m_gpo);
        chk("in_port", in_port, m_in);
        chk("busy_o", {7'd0, busy_o}, {7'd0, m_busy});
        chk("int_o", {7'd0, int_o}, {7'd0, m_int});
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] val);
        port_id      = BASE | {5'd0, off};
        out_port     = val;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off);
        port_id     = BASE | {5'd0, off};
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    int c_g, c_b, c_i;

    initial begin
        rst_i = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0;
        port_id = 8'h00; out_port = 8'h00;
        tick(); tick();
        chk("rst_gpo", gpo, 8'h00);
        chk("rst_in_port", in_port, 8'h00);
        chk("rst_busy", {7'd0, busy_o}, 8'h00);
        rst_i = 1'b1;
        tick();

        // Data path
        wr(3'd1, 8'hFF);
        wr(3'd0, 8'hA5);
        tick();
        chk("gpo_a5", gpo, 8'hA5);
        rd(3'd0);
        chk("rd_data", in_port, 8'hA5);
        wr(3'd2, 8'h0F); tick(); chk("gpo_set", gpo, 8'hAF);
        wr(3'd3, 8'h81); tick(); chk("gpo_clr", gpo, 8'h2E);
        wr(3'd4, 8'hFF); tick(); chk("gpo_tog", gpo, 8'hD1);
        wr(3'd1, 8'h0F); tick(); chk("gpo_en", gpo, 8'h01);

        // Single pulse
        wr(3'd6, 8'd5); wr(3'd0, 8'h00); wr(3'd1, 8'hFF);
        wr(3'd5, 8'h03);
        c_g = (gpo == 8'h03) ? 1 : 0; c_b = busy_o ? 1 : 0; c_i = int_o ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            c_g += (gpo == 8'h03) ? 1 : 0; c_b += busy_o ? 1 : 0; c_i += int_o ? 1 : 0;
        end
        chk("pulse_gpo_cycles", 8'(c_g), PEN ? 8'd5 : 8'd0);
        chk("pulse_busy_cycles", 8'(c_b), PEN ? 8'd5 : 8'd0);
        chk("pulse_int_count", 8'(c_i), PEN ? 8'd1 : 8'd0);
        rd(3'd7); chk("status_done", in_port, PEN ? 8'h02 : 8'h00);
        rd(3'd7); chk("status_clr", in_port, 8'h00);

        // Retrigger
        wr(3'd6, 8'd4);
        wr(3'd5, 8'h01);
        c_i = int_o ? 1 : 0;
        tick(); c_i += int_o ? 1 : 0;
        tick(); c_i += int_o ? 1 : 0;
        wr(3'd5, 8'h10);
        c_i += int_o ? 1 : 0;
        c_g = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            c_g += (gpo == 8'h11) ? 1 : 0; c_i += int_o ? 1 : 0;
        end
        chk("retrig_cycles", 8'(c_g), PEN ? 8'd4 : 8'd0);
        chk("retrig_int_count", 8'(c_i), PEN ? 8'd1 : 8'd0);

        // Zero length is ignored
        wr(3'd6, 8'd0);
        wr(3'd5, 8'hFF);
        c_b = busy_o ? 1 : 0; c_i = int_o ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick(); c_b += busy_o ? 1 : 0; c_i += int_o ? 1 : 0;
        end
        chk("len0_busy", 8'(c_b), 8'd0);
        chk("len0_int", 8'(c_i), 8'd0);

        // Reset during a pulse
        wr(3'd6, 8'd5);
        wr(3'd5, 8'h03);
        tick(); tick();
        rst_i = 1'b0;
        tick();
        chk("midrst_gpo", gpo, 8'h00);
        chk("midrst_in_port", in_port, 8'h00);
        chk("midrst_busy", {7'd0, busy_o}, 8'h00);
        chk("midrst_int", {7'd0, int_o}, 8'h00);
        rst_i = 1'b1;
        c_i = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); c_i += int_o ? 1 : 0;
        end
        chk("midrst_no_int", 8'(c_i), 8'd0);
        rd(3'd6);
        chk("len_rst_val", in_port, PEN ? PLRST : 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_i = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) == 0) port_id = 8'($urandom);
            else port_id = BASE | 8'($urandom_range(0, 7));
            write_strobe = ($urandom_range(0, 2) == 0);
            read_strobe  = ($urandom_range(0, 3) == 0);
            if (port_id[2:0] == 3'd6) out_port = 8'($urandom_range(0, 6));
            else if ($urandom_range(0, 5) == 0) out_port = 8'h00;
            else out_port = 8'($urandom);
            tick();
        end
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
